// File: rtl/rob_pkg.sv
// Shared definitions for the reorder-buffer controller: entry field layout, command types and
// the head-readiness rule.
package rob_pkg;

  localparam int unsigned EntryW        = 77;
  localparam int unsigned CmdLsb        = 75;
  localparam int unsigned CmdW          = 2;
  localparam int unsigned ArchRegLsb    = 70;
  localparam int unsigned ArchRegW      = 5;
  localparam int unsigned FlagsValidBit = 69;
  localparam int unsigned FlagsLsb      = 65;
  localparam int unsigned FlagsW        = 4;
  localparam int unsigned ValueValidBit = 64;
  localparam int unsigned ValueLsb      = 0;
  localparam int unsigned ValueW        = 64;

  typedef enum logic [CmdW-1:0] {
    CMD_NONE = 2'b00,
    CMD_REG  = 2'b01,
    CMD_FLAG = 2'b10,
    CMD_BOTH = 2'b11
  } cmd_e;

  // An entry may retire once every result its command writes back has arrived.
  function automatic logic entry_ready(input logic [EntryW-1:0] entry);
    logic value_ok;
    logic flags_ok;
    logic ready;
    value_ok = entry[ValueValidBit];
    flags_ok = entry[FlagsValidBit];
    ready    = 1'b0;
    unique case (cmd_e'(entry[CmdLsb +: CmdW]))
      CMD_NONE, CMD_REG: ready = value_ok;
      CMD_FLAG:          ready = flags_ok;
      CMD_BOTH:          ready = value_ok & flags_ok;
      default:           ready = 1'b0;
    endcase
    return ready;
  endfunction

endpackage

// File: rtl/rob_ctrl_if.sv
// Decode/commit/storage signal bundle of the ROB controller; slave is the controller side,
// master is the pipeline/storage side.
interface rob_ctrl_if
  import rob_pkg::*;
#(
  parameter int unsigned ROBsize  = 32,
  parameter int unsigned addrSize = $clog2(ROBsize)
);

  logic                flush_i;
  logic                allocReq_i;
  logic                allocGrant_o;
  logic [addrSize-1:0] allocTag_o;
  logic [addrSize-1:0] commitReadAddr_o;
  logic [EntryW-1:0]   commitReadData_i;
  logic                commitReady_i;
  logic                commitValid_o;
  logic                commitRegWe_o;
  logic                commitFlagWe_o;
  logic [ArchRegW-1:0] commitArchReg_o;
  logic [ValueW-1:0]   commitValue_o;
  logic [FlagsW-1:0]   commitFlags_o;
  logic [ROBsize-1:0]  resets_o;
  logic [addrSize:0]   count_o;
  logic                full_o;
  logic                empty_o;

  modport slave (
    input  flush_i, allocReq_i, commitReadData_i, commitReady_i,
    output allocGrant_o, allocTag_o, commitReadAddr_o, commitValid_o, commitRegWe_o,
           commitFlagWe_o, commitArchReg_o, commitValue_o, commitFlags_o, resets_o, count_o,
           full_o, empty_o
  );

  modport master (
    output flush_i, allocReq_i, commitReadData_i, commitReady_i,
    input  allocGrant_o, allocTag_o, commitReadAddr_o, commitValid_o, commitRegWe_o,
           commitFlagWe_o, commitArchReg_o, commitValue_o, commitFlags_o, resets_o, count_o,
           full_o, empty_o
  );

endinterface

// File: rtl/rob_ptr.sv
// Wrapping ring pointer with increment enable and synchronous clear.
module rob_ptr #(
  parameter int unsigned Width = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [Width-1:0] o_ptr
);

  logic [Width-1:0] r_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + Width'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer control: hands out tail tags to decode, retires the head in program order and
// clears retired or flushed entries in the ROB storage.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int unsigned ROBsize  = 32,
  parameter int unsigned addrSize = $clog2(ROBsize)
) (
  input  logic clk_i,
  input  logic reset_ni,
  rob_ctrl_if.slave bus
);

  logic [addrSize-1:0] w_head;
  logic [addrSize-1:0] w_tail;
  logic [addrSize:0]   r_count;
  logic                w_full;
  logic                w_empty;
  logic                w_grant;
  logic                w_alloc;
  logic                w_commit;
  logic [CmdW-1:0]     w_cmd;
  logic [ROBsize-1:0]  w_resets;

  assign w_full  = (r_count == (addrSize+1)'(ROBsize));
  assign w_empty = (r_count == '0);

  // Grant is independent of same-cycle retirement to keep commit off the decode path.
  assign w_grant  = ~w_full & ~bus.flush_i;
  assign w_alloc  = bus.allocReq_i & w_grant;
  assign w_cmd    = bus.commitReadData_i[CmdLsb +: CmdW];
  assign w_commit = ~w_empty & entry_ready(bus.commitReadData_i) & bus.commitReady_i &
                    ~bus.flush_i;

  always_comb begin
    w_resets = '0;
    if (!reset_ni || bus.flush_i) begin
      w_resets = '1;
    end else if (w_commit) begin
      w_resets[w_head] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_count <= '0;
    end else if (bus.flush_i) begin
      r_count <= '0;
    end else if (w_alloc && !w_commit) begin
      r_count <= r_count + (addrSize+1)'(1);
    end else if (!w_alloc && w_commit) begin
      r_count <= r_count - (addrSize+1)'(1);
    end
  end

  rob_ptr #(
    .Width (addrSize)
  ) u_head_ptr (
    .i_clk   (clk_i),
    .i_rst_n (reset_ni),
    .i_clr   (bus.flush_i),
    .i_inc   (w_commit),
    .o_ptr   (w_head)
  );

  rob_ptr #(
    .Width (addrSize)
  ) u_tail_ptr (
    .i_clk   (clk_i),
    .i_rst_n (reset_ni),
    .i_clr   (bus.flush_i),
    .i_inc   (w_alloc),
    .o_ptr   (w_tail)
  );

  assign bus.allocGrant_o     = w_grant;
  assign bus.allocTag_o       = w_tail;
  assign bus.commitReadAddr_o = w_head;
  assign bus.commitValid_o    = w_commit;
  assign bus.commitRegWe_o    = w_commit & w_cmd[0];
  assign bus.commitFlagWe_o   = w_commit & w_cmd[1];
  assign bus.commitArchReg_o  = bus.commitReadData_i[ArchRegLsb +: ArchRegW];
  assign bus.commitValue_o    = bus.commitReadData_i[ValueLsb +: ValueW];
  assign bus.commitFlags_o    = bus.commitReadData_i[FlagsLsb +: FlagsW];
  assign bus.resets_o         = w_resets;
  assign bus.count_o          = r_count;
  assign bus.full_o           = w_full;
  assign bus.empty_o          = w_empty;

endmodule

// File: tb/tb_rob_ctrl.sv
// Scoreboard bench for rob_ctrl with an 8-entry ROB; the bench models the entry storage itself.
module tb_rob_ctrl;

  localparam int N = 8;

  typedef struct {
    int         tag;
    logic [1:0] cmd;
    logic [4:0] areg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rob_ctrl_if #(.ROBsize(N)) bus ();

  rob_ctrl #(.ROBsize(N)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [76:0] mem [N];
  logic [63:0] e_val [N];
  logic [3:0]  e_flg [N];
  exp_t        sb [$];
  int          m_head, m_tail, m_count;
  int          n_checks = 0;
  int          n_errors = 0;

  always_comb bus.commitReadData_i = mem[bus.commitReadAddr_o];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic head_rdy(input logic [76:0] e);
    logic vv, fv;
    vv = e[64];
    fv = e[69];
    case (e[76:75])
      2'b10:   return fv;
      2'b11:   return vv && fv;
      default: return vv;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mem[i] = '0;
    m_head = 0;
    m_tail = 0;
    m_count = 0;
    sb.delete();
  endtask

  task automatic complete(input int tag, input logic vv, input logic fv,
                          input logic [63:0] val, input logic [3:0] flg);
    if (vv) begin
      mem[tag][64]   = 1'b1;
      mem[tag][63:0] = val;
      e_val[tag]     = val;
    end
    if (fv) begin
      mem[tag][69]    = 1'b1;
      mem[tag][68:65] = flg;
      e_flg[tag]      = flg;
    end
  endtask

  task automatic reset_checks();
    chk("rst_resets", 64'(bus.resets_o), 64'hFF);
    chk("rst_grant", 64'(bus.allocGrant_o), 64'd1);
    chk("rst_cvalid", 64'(bus.commitValid_o), 64'd0);
    chk("rst_tag", 64'(bus.allocTag_o), 64'd0);
    chk("rst_addr", 64'(bus.commitReadAddr_o), 64'd0);
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_empty", 64'(bus.empty_o), 64'd1);
    chk("rst_full", 64'(bus.full_o), 64'd0);
  endtask

  // One clock: drive, check combinational outputs against the model, then advance the model.
  task automatic tick(input logic req, input logic rdy, input logic fl,
                      input logic [1:0] cmd, input logic [4:0] areg);
    logic       eg, ecv, do_alloc;
    logic [7:0] er;
    exp_t       e;
    bus.allocReq_i    = req;
    bus.commitReady_i = rdy;
    bus.flush_i       = fl;
    #1;
    eg  = (m_count != N) && !fl;
    ecv = (m_count != 0) && head_rdy(mem[m_head]) && rdy && !fl;
    er  = fl ? 8'hFF : (ecv ? (8'd1 << m_head) : 8'h00);
    chk("grant", 64'(bus.allocGrant_o), 64'(eg));
    chk("tag", 64'(bus.allocTag_o), 64'(m_tail));
    chk("cvalid", 64'(bus.commitValid_o), 64'(ecv));
    chk("count", 64'(bus.count_o), 64'(m_count));
    chk("full", 64'(bus.full_o), 64'(m_count == N));
    chk("empty", 64'(bus.empty_o), 64'(m_count == 0));
    chk("resets", 64'(bus.resets_o), 64'(er));
    if (ecv) begin
      e = sb.pop_front();
      chk("c_addr", 64'(bus.commitReadAddr_o), 64'(e.tag));
      chk("reg_we", 64'(bus.commitRegWe_o), 64'(e.cmd[0]));
      chk("flag_we", 64'(bus.commitFlagWe_o), 64'(e.cmd[1]));
      if (e.cmd[0]) begin
        chk("c_reg", 64'(bus.commitArchReg_o), 64'(e.areg));
        chk("c_val", bus.commitValue_o, e_val[e.tag]);
      end
      if (e.cmd[1]) chk("c_flags", 64'(bus.commitFlags_o), 64'(e_flg[e.tag]));
    end
    do_alloc = req && eg;
    @(posedge clk);
    #1;
    if (fl) begin
      model_clear();
    end else begin
      if (ecv) begin
        mem[m_head] = '0;
        m_head = (m_head + 1) % N;
      end
      if (do_alloc) begin
        mem[m_tail] = {cmd, areg, 70'd0};
        sb.push_back('{tag: m_tail, cmd: cmd, areg: areg});
        m_tail = (m_tail + 1) % N;
      end
      m_count = m_count + int'(do_alloc) - int'(ecv);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.allocReq_i    = 1'b0;
    bus.commitReady_i = 1'b0;
    bus.flush_i       = 1'b0;
    model_clear();
    #1;
    reset_checks();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, then a ninth request must be refused.
    for (int i = 0; i < N; i++) tick(1'b1, 1'b0, 1'b0, 2'b01, 5'(i + 1));
    tick(1'b1, 1'b0, 1'b0, 2'b01, 5'd20);

    // Full with a ready head: retire while grant stays low, then the freed slot wraps.
    complete(0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 4'h0);
    tick(1'b1, 1'b1, 1'b0, 2'b01, 5'd21);
    tick(1'b1, 1'b0, 1'b0, 2'b01, 5'd9);
    tick(1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
    tick(1'b1, 1'b1, 1'b1, 2'b01, 5'd0);

    // Five entries then flush.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 2'b11, 5'(i));
    complete(0, 1'b1, 1'b1, 64'h55, 4'h5);
    tick(1'b0, 1'b1, 1'b1, 2'b00, 5'd0);
    tick(1'b0, 1'b0, 1'b0, 2'b00, 5'd0);

    // Out-of-order completion, in-order retirement.
    tick(1'b1, 1'b0, 1'b0, 2'b01, 5'd3);
    tick(1'b1, 1'b0, 1'b0, 2'b10, 5'd4);
    tick(1'b1, 1'b0, 1'b0, 2'b11, 5'd5);
    complete(2, 1'b1, 1'b1, 64'h2222_3333_4444_5555, 4'hA);
    tick(1'b0, 1'b1, 1'b0, 2'b00, 5'd0);
    complete(0, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 4'h0);
    complete(1, 1'b0, 1'b1, 64'h0, 4'h6);
    repeat (4) tick(1'b0, 1'b1, 1'b0, 2'b00, 5'd0);

    // Reg+flag head with only the value back is not ready; then back-pressure holds it.
    tick(1'b1, 1'b0, 1'b0, 2'b11, 5'd17);
    complete(3, 1'b1, 1'b0, 64'hFEED_F00D_CAFE_0003, 4'h0);
    tick(1'b0, 1'b1, 1'b0, 2'b00, 5'd0);
    complete(3, 1'b0, 1'b1, 64'h0, 4'h9);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
    tick(1'b0, 1'b1, 1'b0, 2'b00, 5'd0);

    // Mixed random traffic.
    for (int k = 0; k < 80; k++) begin
      if (sb.size() > 0 && $urandom_range(0, 1) == 1) begin
        int j;
        j = $urandom_range(0, sb.size() - 1);
        complete(sb[j].tag, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, 4'($urandom));
      end
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0,
           2'($urandom), 5'($urandom));
    end

    // Asynchronous reset with three entries live and a ready head.
    tick(1'b0, 1'b0, 1'b1, 2'b00, 5'd0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 2'b01, 5'(i + 7));
    complete(0, 1'b1, 1'b0, 64'h77, 4'h0);
    bus.allocReq_i    = 1'b1;
    bus.commitReady_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 2'b01, 5'd1);
    tick(1'b0, 1'b0, 1'b0, 2'b00, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rob_ctrl.md
# rob_ctrl

Reorder-buffer control for the out-of-order pipeline. It owns the head/tail pointers and occupancy of the ROB entry storage (`ROBregs`). It hands ROB tags to decode and retires the head entry in program order once its completion data is valid. At retirement it drives architectural register-file and flag writeback and clears retired or flushed entries through the storage's per-entry reset lines.

## Interface
Parameters:
- `ROBsize`, 32, number of ROB entries; power of two, ≥ 4.
- `addrSize`, `$clog2(ROBsize)`, tag/pointer width.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_ni`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  synchronous flush of all entries (mispredict/exception).
- `allocReq_i`  in  1  decode requests one ROB entry this cycle.
- `allocGrant_o`  out  1  entry granted; allocation occurs when req & grant.
- `allocTag_o`  out  addrSize  tag of the granted entry (current tail); feeds `ROBregs` decode write address.
- `commitReadAddr_o`  out  addrSize  current head; feeds `ROBregs` commit read address.
- `commitReadData_i`  in  77  head entry from `ROBregs`: [76:75] cmd type, [74:70] arch reg, [69] flagsValid, [68:65] NZCV, [64] valueValid, [63:0] value.
- `commitReady_i`  in  1  arch reg file / flag register can accept a writeback this cycle.
- `commitValid_o`  out  1  head retires this cycle.
- `commitRegWe_o`  out  1  write `commitValue_o` to `commitArchReg_o`.
- `commitFlagWe_o`  out  1  write `commitFlags_o` to flag register.
- `commitArchReg_o`  out  5  destination arch register.
- `commitValue_o`  out  64  retired value.
- `commitFlags_o`  out  4  retired NZCV.
- `resets_o`  out  ROBsize  per-entry clear to `ROBregs` `resets_i`.
- `count_o`  out  addrSize+1  occupancy.
- `full_o`, `empty_o`  out  1  count == ROBsize / count == 0.

## Operation
- State: `head`, `tail` (addrSize, natural wrap modulo ROBsize), `count` (addrSize+1).
- Allocation: `allocGrant_o = !full_o & !flush_i`. Grant does not depend on same-cycle commit, so there is no combinational path from commit to decode. On req & grant: tail += 1, count += 1.
- Cmd type: 00 no writeback; 01 reg write; 10 flag write; 11 reg + flag.
- Head ready: types 00/01 need valueValid; type 10 needs flagsValid; type 11 needs both.
- `commitValid_o = !empty_o & ready(head) & commitReady_i & !flush_i`.
- `commitRegWe_o = commitValid_o & type[0]`; `commitFlagWe_o = commitValid_o & type[1]`.
- Data outputs pass through from `commitReadData_i` combinationally; they are don't-care when `commitValid_o` = 0.
- On commit: `resets_o[head]` = 1 in the same cycle, so the entry clears at the edge; head += 1, count −= 1.
- Simultaneous alloc + commit: count unchanged; both pointers advance.
- Alloc and reset can never target the same entry: when empty nothing commits, and when full nothing is granted.
- Flush: `resets_o` = all ones; head = tail = count = 0 at the edge; no commit and no grant in the flush cycle.
- Reset: `resets_o` = all ones while `reset_ni` low. Head, tail and count are 0. `empty_o` = 1, `full_o` = 0, `allocGrant_o` = 1, `commitValid_o` = 0, `allocTag_o` = 0, `commitReadAddr_o` = 0.

## Timing
- Allocation latency 0: the tag is valid in the same cycle as the grant, and the entry is written by `ROBregs` at that edge.
- Retirement is 1 per cycle maximum. A head whose completion lands at edge N can commit in cycle N (combinational readiness from the stored entry).
- `count_o`, `full_o`, `empty_o` are registered-state derived and glitch-free with respect to requests.
- Mid-operation reset clears all state asynchronously; the first grant is available in the cycle after deassertion.

## Structure
- Package `rob_pkg`:
  - field offset/width constants for the 77-bit entry;
  - cmd type enum (`CMD_NONE`, `CMD_REG`, `CMD_FLAG`, `CMD_BOTH`);
  - arch-reg width constant.
- Sub-module `rob_ptr` (wrapping pointer with increment enable and synchronous clear) is instantiated twice, for head and tail.
- Per-entry reset one-hot is generated inline.

## Test plan
(All scenarios use ROBsize = 8.)
- Reset, then 8 back-to-back allocs with no completions → tags 0..7, `full_o` = 1 after 8th, 9th request gets `allocGrant_o` = 0, `count_o` = 8.
- Fill tags 0–2 (types 01, 10, 11), complete tag 2 first with both valids → no commit. Then complete 0 and 1 → commits in order 0, 1, 2 on consecutive cycles, with correct `commitRegWe_o`/`commitFlagWe_o`, and `resets_o` one-hot 0x01, 0x02, 0x04.
- Head ready with `commitReady_i` = 0 for 3 cycles → `commitValid_o` = 0 and head holds; it commits in the cycle `commitReady_i` rises.
- Full ROB with ready head plus allocReq in the same cycle → commit occurs, grant stays 0. Next cycle grant = 1 with tag equal to the old head (wrap-around), count back to 8.
- Fill 5 entries then pulse `flush_i` → `resets_o` = 0xFF, no commit that cycle; next cycle count 0, `allocTag_o` = 0, empty.
- Assert `reset_ni` low mid-stream with count = 3 → outputs immediately return to the reset values listed above.
